// File: rtl/cpu_pkg.sv
// cpu_pkg: shared redirect-kind encodings and default PC vectors for the core
package cpu_pkg;
  typedef enum logic [1:0] {
    RK_BRANCH = 2'd0,
    RK_JUMP   = 2'd1,
    RK_JR     = 2'd2,
    RK_ERET   = 2'd3
  } redir_kind_t;
  localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] EXC_VECTOR   = 32'h0000_0004;
endpackage

// File: rtl/pc_target_calc.sv
// pc_target_calc: resolves a redirect target and flags misalignment
// Ports:
//   redir_kind   - branch / jump / jr / eret
//   redir_target - absolute target, or jump index in the low JUMP_BITS
//   pc_plus4     - sequential PC supplying the jump region bits
//   epc          - return address used by eret
//   target       - resolved absolute target
//   misaligned   - target is not word aligned
module pc_target_calc
  import cpu_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int JUMP_BITS = 28
) (
  input  logic [1:0]       redir_kind,
  input  logic [WIDTH-1:0] redir_target,
  input  logic [WIDTH-1:0] pc_plus4,
  input  logic [WIDTH-1:0] epc,
  output logic [WIDTH-1:0] target,
  output logic             misaligned
);
  always_comb begin
    target = redir_kind == RK_JUMP ? {pc_plus4[WIDTH-1:JUMP_BITS], redir_target[JUMP_BITS-1:0]} :
             redir_kind == RK_ERET ? epc : redir_target;
    misaligned = |target[1:0];
  end
endmodule

// File: rtl/pc_unit.sv
// pc_unit: program counter with next-PC selection, stall-safe redirect buffer, EPC and alignment trap
// Ports:
//   clk, rst      - clock; asynchronous active-high reset
//   stall         - hold the PC this cycle
//   redir_valid   - redirect request; redir_kind / redir_target describe it
//   exc_req       - synchronous exception, overrides everything including stall
//   pc_out        - current PC
//   pc_plus4      - pc_out + INC (combinational, wraps)
//   epc_out       - exception PC
//   redir_pending - a redirect captured during a stall is waiting
//   align_fault   - one-cycle pulse when a misaligned target was trapped
module pc_unit
  import cpu_pkg::*;
#(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(cpu_pkg::RESET_VECTOR),
  parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(cpu_pkg::EXC_VECTOR),
  parameter int               JUMP_BITS    = 28,
  parameter int               INC          = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             redir_valid,
  input  logic [1:0]       redir_kind,
  input  logic [WIDTH-1:0] redir_target,
  input  logic             exc_req,
  output logic [WIDTH-1:0] pc_out,
  output logic [WIDTH-1:0] pc_plus4,
  output logic [WIDTH-1:0] epc_out,
  output logic             redir_pending,
  output logic             align_fault
);
  logic [WIDTH-1:0] live_target, pend_target, apply_target;
  logic             live_misaligned, take;
  assign pc_plus4 = pc_out + WIDTH'(INC);
  pc_target_calc #(.WIDTH(WIDTH), .JUMP_BITS(JUMP_BITS)) u_calc (
    .redir_kind  (redir_kind),
    .redir_target(redir_target),
    .pc_plus4    (pc_plus4),
    .epc         (epc_out),
    .target      (live_target),
    .misaligned  (live_misaligned)
  );
  // A live redirect beats a buffered one; the buffered target was resolved at capture
  // time, so only its alignment is evaluated here, when it is actually applied.
  always_comb begin
    take         = redir_valid | redir_pending;
    apply_target = redir_valid ? live_target : pend_target;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_out        <= RESET_VECTOR;
      epc_out       <= '0;
      redir_pending <= 1'b0;
      pend_target   <= '0;
      align_fault   <= 1'b0;
    end else begin
      align_fault <= 1'b0;
      if (exc_req) begin
        pc_out        <= EXC_VECTOR;
        epc_out       <= pc_out;
        redir_pending <= 1'b0;
      end else if (!stall) begin
        redir_pending <= 1'b0;
        if (take && (redir_valid ? live_misaligned : |pend_target[1:0])) begin
          pc_out      <= EXC_VECTOR;
          epc_out     <= apply_target;
          align_fault <= 1'b1;
        end else begin
          pc_out <= take ? apply_target : pc_plus4;
        end
      end else if (redir_valid) begin
        pend_target   <= live_target;
        redir_pending <= 1'b1;
      end
    end
  end
endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised program-counter unit for the single-cycle MIPS core; replaces the bare enable-gated PC register.
- Holds the PC and forms the next PC itself: sequential, branch, jump, jr, eret, exception.
- Adds a one-entry pending-redirect buffer so a redirect raised during a stall is not lost.
- Adds an EPC register and misalignment trapping. Sits between the control unit and instruction memory.

Parameters:
WIDTH, 32, PC / address width in bits (>= JUMP_BITS+1)
RESET_VECTOR, 0, PC value after reset
EXC_VECTOR, 32'h0000_0004, PC loaded on exception or misaligned redirect
JUMP_BITS, 28, low bits replaced by a jump target; upper bits come from pc_plus4
INC, 4, sequential increment in bytes

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
stall  in  1  hold PC this cycle
redir_valid  in  1  redirect request this cycle
redir_kind  in  2  0=branch, 1=jump, 2=jr, 3=eret
redir_target  in  WIDTH  branch/jr absolute target; jump index in the low JUMP_BITS
exc_req  in  1  synchronous exception (syscall/break/overflow)
pc_out  out  WIDTH  current PC
pc_plus4  out  WIDTH  pc_out+INC, combinational
epc_out  out  WIDTH  exception PC register
redir_pending  out  1  a buffered redirect is waiting
align_fault  out  1  one-cycle registered pulse on misaligned target

Behaviour:
- Reset (async, rst=1):
  - pc_out=RESET_VECTOR, epc_out=0, redir_pending=0, align_fault=0.
  - Pending buffer cleared; all state held while rst stays high.
- Target formation for redirect kind k:
  - branch/jr: redir_target.
  - jump: {pc_plus4[WIDTH-1:JUMP_BITS], redir_target[JUMP_BITS-1:0]}.
  - eret: epc_out; redir_target ignored.
- Arithmetic:
  - pc_plus4 wraps modulo 2^WIDTH.
  - 0xFFFF_FFFC + 4 = 0x0000_0000, no flag.
- Per-edge priority (highest first):
  1. exc_req: pc<=EXC_VECTOR, epc<=pc_out, pending cleared. Ignores stall.
  2. Not stalled, redir_valid=1: the live redirect is taken, and a buffered one is discarded (live wins).
  3. Not stalled, pending=1: the buffered target is taken; pending<=0.
  4. Not stalled, none of the above: pc<=pc_plus4.
  5. Stalled: pc holds. If redir_valid, the resolved target is stored and pending<=1. A newer redirect overwrites an older one; the target is resolved at capture time, so jump uses the stalled PC.
- Misalignment:
  - Applies to any target about to be loaded (live or buffered) with target[1:0]!=0.
  - Action: pc<=EXC_VECTOR, epc<=faulting target, align_fault<=1 for exactly one cycle, pending cleared.
  - If stalled, the check happens when the target is applied, not when it is captured.
- Latency:
  - Every PC change is visible one edge after its cause.
  - pc_plus4 is same-cycle combinational.
- Reset mid-stall with pending set: the pending buffer is dropped, and the first post-reset fetch is RESET_VECTOR.
- exc_req with redir_valid on the same edge: exception wins and the redirect is dropped.

Decomposition:
- Shared package (cpu_pkg):
  - redir_kind encodings (RK_BRANCH, RK_JUMP, RK_JR, RK_ERET).
  - Default vectors RESET_VECTOR and EXC_VECTOR.
- One natural sub-module: pc_target_calc, combinational.
  - Inputs: redir_kind, redir_target, pc_plus4, epc.
  - Outputs: resolved target and misaligned flag.
  - Used for both the live path and the capture path.
- State registers (pc, epc, pending buffer, fault pulse) stay in pc_unit.

Test Plan:
1. Sequential wrap: reset, then release with RESET_VECTOR=0 -> pc 0x0,0x4,0x8. Force pc to 0xFFFF_FFFC via jr -> next pc 0x0.
2. Jump formation: pc=0x1000_0040, jump with redir_target=0x0000_0100 -> pc=0x1000_0100 next edge.
3. Stall buffering: stall=1 for 3 cycles at pc=0x20; branch 0x80 in stall cycle 1, then branch 0x90 in cycle 2.
   - redir_pending=1 from the next edge; pc holds 0x20.
   - After release, pc=0x90 and pending=0.
4. Exception/eret: pc=0x44, exc_req -> pc=0x4, epc=0x44. Later eret -> pc=0x44.
5. Misaligned jr to 0x102 -> pc=0x4, epc=0x102, align_fault high exactly one cycle.
6. Async reset during stall with pending=1: assert rst between edges -> pc_out=RESET_VECTOR immediately, pending=0. After release, pc advances sequentially from RESET_VECTOR.
